// File: rtl/apb_ctud_bank.sv
// apb_ctud_bank: APB3 bank of 2**CH_BITS IEC 61131-3 up/down counters. Optional IRQ under `CTUD_IRQ_EN`.
module apb_ctud_bank #(
    parameter int DATA_W  = 32,
    parameter int CH_BITS = 3,
    parameter int ADDR_W  = 16
) (
    input  logic              i_pclk,
    input  logic              i_preset,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic [DATA_W-1:0] i_pwdata,
    output logic [DATA_W-1:0] o_prdata,
    output logic              o_pready,
    output logic              o_pslverr
`ifdef CTUD_IRQ_EN
    ,
    output logic              o_irq
`endif
);
    localparam int NCH = 1 << CH_BITS;
    localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [3:0]        r_ctrl [NCH];
    logic [DATA_W-1:0] r_pv   [NCH];
    logic [DATA_W-1:0] r_cv   [NCH];
    logic [2:0]        r_mode [NCH];
    logic [NCH-1:0]    r_ovf, r_unf;
    logic [NCH-1:0]    w_qu, w_qd;
    logic              w_acc, w_wr, w_err, w_up, w_dn, w_cnt, w_at_max, w_at_min, w_set_ovf, w_set_unf;
    logic [CH_BITS-1:0] w_ch;
    logic [2:0]        w_reg, w_mode;
    logic [3:0]        w_old, w_new;
    logic [DATA_W-1:0] w_cv, w_cv_nxt, w_rd;
    logic              w_unused;

    assign w_acc    = i_psel & i_penable;
    assign w_wr     = w_acc & i_pwrite;
    assign w_ch     = i_paddr[CH_BITS+4:5];
    assign w_reg    = i_paddr[4:2];
    assign w_err    = w_reg > 3'd4;
    assign w_unused = ^{i_paddr[ADDR_W-1:CH_BITS+5], i_paddr[1:0]};

    assign w_old    = r_ctrl[w_ch];
    assign w_new    = i_pwdata[3:0];
    assign w_mode   = r_mode[w_ch];
    assign w_cv     = r_cv[w_ch];
    // CTD and hold block up edges; CTU and hold block down edges; simultaneous edges cancel
    assign w_up     = w_new[0] & ~w_old[0] & ~w_mode[1] & ~(w_new[1] & ~w_old[1] & ~w_mode[0]);
    assign w_dn     = w_new[1] & ~w_old[1] & ~w_mode[0] & ~(w_new[0] & ~w_old[0] & ~w_mode[1]);
    assign w_cnt    = ~w_new[2] & ~w_new[3];
    assign w_at_max = w_cv == MAXV;
    assign w_at_min = w_cv == MINV;
    assign w_set_ovf = w_cnt & w_up & w_at_max;
    assign w_set_unf = w_cnt & w_dn & w_at_min;
    assign w_cv_nxt = w_new[2] ? '0 :
                      w_new[3] ? r_pv[w_ch] :
                      w_up ? (w_at_max ? (w_mode[2] ? MAXV : MINV) : w_cv + ONE) :
                      w_dn ? (w_at_min ? (w_mode[2] ? MINV : MAXV) : w_cv - ONE) : w_cv;

    assign o_pready  = 1'b1;
    assign o_pslverr = w_acc & w_err;
    assign o_prdata  = (i_psel & ~i_pwrite) ? w_rd : '0;

    // per-channel outputs from stored CV/PV, signed compares
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_qu[c] = $signed(r_cv[c]) >= $signed(r_pv[c]);
            w_qd[c] = r_cv[c][DATA_W-1] | (r_cv[c] == '0);
        end
    end

`ifdef CTUD_IRQ_EN
    logic [NCH-1:0] r_ie, r_ip, r_qu_d, w_ip_clr;
    logic           r_irq;
    assign w_ip_clr = {{(NCH-1){1'b0}}, w_wr & (w_reg == 3'd3) & i_pwdata[4]} << w_ch;
    assign o_irq    = r_irq;
    // pending latches a QU rise (QU history resets high, matching CV=PV=0); set beats W1C
    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_ie   <= '0;
            r_ip   <= '0;
            r_qu_d <= '1;
            r_irq  <= 1'b0;
        end else begin
            r_qu_d <= w_qu;
            r_ip   <= (r_ip & ~w_ip_clr) | (w_qu & ~r_qu_d);
            r_irq  <= |(r_ip & r_ie);
            if (w_wr && w_reg == 3'd4)
                r_ie[w_ch] <= i_pwdata[3];
        end
    end
`endif

    // read mux for the addressed channel register; reserved offsets read 0
    always_comb begin
        w_rd = '0;
        case (w_reg)
            3'd0: w_rd[3:0] = r_ctrl[w_ch];
            3'd1: w_rd = r_pv[w_ch];
            3'd2: w_rd = r_cv[w_ch];
            3'd3: w_rd[3:0] = {r_unf[w_ch], r_ovf[w_ch], w_qd[w_ch], w_qu[w_ch]};
            3'd4: w_rd[2:0] = r_mode[w_ch];
            default: w_rd = '0;
        endcase
`ifdef CTUD_IRQ_EN
        if (w_reg == 3'd3)
            w_rd[4] = r_ip[w_ch];
        if (w_reg == 3'd4)
            w_rd[3] = r_ie[w_ch];
`endif
    end

    // register writes; a CTRL write also applies reset/load/count to CV at the same edge
    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            for (int c = 0; c < NCH; c++) begin
                r_ctrl[c] <= '0;
                r_pv[c]   <= '0;
                r_cv[c]   <= '0;
                r_mode[c] <= '0;
            end
            r_ovf <= '0;
            r_unf <= '0;
        end else if (w_wr) begin
            case (w_reg)
                3'd0: begin
                    r_ctrl[w_ch] <= w_new;
                    r_cv[w_ch]   <= w_cv_nxt;
                    r_ovf[w_ch]  <= r_ovf[w_ch] | w_set_ovf;
                    r_unf[w_ch]  <= r_unf[w_ch] | w_set_unf;
                end
                3'd1: r_pv[w_ch] <= i_pwdata;
                3'd3: begin
                    if (i_pwdata[2])
                        r_ovf[w_ch] <= 1'b0;
                    if (i_pwdata[3])
                        r_unf[w_ch] <= 1'b0;
                end
                3'd4: r_mode[w_ch] <= i_pwdata[2:0];
                default: ;
            endcase
        end
    end
endmodule
